irrigation_countdown_timer: RTL and testbench

Parametrised successor to the irrigation timer reset/preset logic. Owns the full irrigation countdown: it loads a mode-dependent MM:SS preset (sprinkler or dripper), decrements it once per second using an internal prescaler, and reports done or abort. It sits between the irrigation controller FSM (start/abort conditions) and the 7-segment display driver (BCD digits).

---
 rtl/irrigation_timer_pkg.sv | 37 +++
 rtl/bcd_mmss_down_counter.sv | 53 +++++
 rtl/irrigation_countdown_timer.sv | 159 +++++++++++++++
 tb/tb_irrigation_countdown_timer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/irrigation_timer_pkg.sv
// Shared types, digit widths and preset helpers for the irrigation countdown timer.
package irrigation_timer_pkg;

  localparam int unsigned MIN_D_W = 4;
  localparam int unsigned MIN_U_W = 4;
  localparam int unsigned SEC_D_W = 3;
  localparam int unsigned SEC_U_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MIN_D_W-1:0] min_d;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [SEC_U_W-1:0] sec_u;
  } mmss_t;

  // Binary minutes/seconds to packed BCD digits.
  function automatic mmss_t to_mmss(input int unsigned mins, input int unsigned secs);
    mmss_t r;
    r.min_d = MIN_D_W'(mins / 10);
    r.min_u = MIN_U_W'(mins % 10);
    r.sec_d = SEC_D_W'(secs / 10);
    r.sec_u = SEC_U_W'(secs % 10);
    return r;
  endfunction

  // A preset must fit MM:SS and must not be 00:00.
  function automatic bit preset_ok(input int unsigned mins, input int unsigned secs);
    return (mins <= 99) && (secs <= 59) && ((mins != 0) || (secs != 0));
  endfunction

endpackage

// File: rtl/bcd_mmss_down_counter.sv
// MM:SS BCD down counter with load, clear and borrow-chained decrement.
module bcd_mmss_down_counter
  import irrigation_timer_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  i_clear,
  input  logic  i_load,
  input  mmss_t i_load_val,
  input  logic  i_dec,
  output mmss_t o_digits,
  output logic  o_zero_c
);

  mmss_t r_digits;

  // Clear beats load beats decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
    end else if (i_clear) begin
      r_digits <= '0;
    end else if (i_load) begin
      r_digits <= i_load_val;
    end else if (i_dec) begin
      if (r_digits.sec_u != '0) begin
        r_digits.sec_u <= r_digits.sec_u - SEC_U_W'(1);
      end else begin
        r_digits.sec_u <= SEC_U_W'(9);
        if (r_digits.sec_d != '0) begin
          r_digits.sec_d <= r_digits.sec_d - SEC_D_W'(1);
        end else begin
          r_digits.sec_d <= SEC_D_W'(5);
          if (r_digits.min_u != '0) begin
            r_digits.min_u <= r_digits.min_u - MIN_U_W'(1);
          end else begin
            r_digits.min_u <= MIN_U_W'(9);
            r_digits.min_d <= r_digits.min_d - MIN_D_W'(1);
          end
        end
      end
    end
  end

  assign o_digits = r_digits;
  assign o_zero_c = (r_digits == '0);

  a_sec_d_range: assert property (@(posedge clock) disable iff (reset) r_digits.sec_d <= SEC_D_W'(5));
  a_sec_u_range: assert property (@(posedge clock) disable iff (reset) r_digits.sec_u <= SEC_U_W'(9));
  a_min_u_range: assert property (@(posedge clock) disable iff (reset) r_digits.min_u <= MIN_U_W'(9));
  a_min_d_range: assert property (@(posedge clock) disable iff (reset) r_digits.min_d <= MIN_D_W'(9));

endmodule

// File: rtl/irrigation_countdown_timer.sv
// Irrigation countdown: loads a mode preset, counts down once per second, reports done/abort.
module irrigation_countdown_timer
  import irrigation_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SECOND = 50_000_000,
  parameter int unsigned SPRINKLER_MIN    = 15,
  parameter int unsigned SPRINKLER_SEC    = 0,
  parameter int unsigned DRIPPER_MIN      = 30,
  parameter int unsigned DRIPPER_SEC      = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               irrigation_on,
  input  logic               conflicting_values,
  input  logic               sprinkler_mode_on,
  input  logic               stop_button,
  output logic [MIN_D_W-1:0] minutes_d,
  output logic [MIN_U_W-1:0] minutes_u,
  output logic [SEC_D_W-1:0] seconds_d,
  output logic [SEC_U_W-1:0] seconds_u,
  output logic               running,
  output logic               done,
  output logic               aborted
);

  localparam int unsigned PRESCALE_W = 32;
  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICKS_PER_SECOND - 1);
  localparam mmss_t SPRINKLER_PRESET = to_mmss(SPRINKLER_MIN, SPRINKLER_SEC);
  localparam mmss_t DRIPPER_PRESET   = to_mmss(DRIPPER_MIN, DRIPPER_SEC);
  localparam mmss_t ONE_SECOND       = to_mmss(0, 1);

  if (TICKS_PER_SECOND == 0) begin : g_bad_ticks
    $error("TICKS_PER_SECOND must be at least 1");
  end
  if (!preset_ok(SPRINKLER_MIN, SPRINKLER_SEC)) begin : g_bad_sprinkler
    $error("sprinkler preset out of range or zero");
  end
  if (!preset_ok(DRIPPER_MIN, DRIPPER_SEC)) begin : g_bad_dripper
    $error("dripper preset out of range or zero");
  end

  state_t                r_state;
  state_t                w_state_next;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_running;
  logic                  r_done;
  logic                  r_aborted;
  logic                  w_running_next;
  logic                  w_done_next;
  logic                  w_aborted_next;
  logic                  w_abort;
  logic                  w_go;
  logic                  w_tick;
  logic                  w_load;
  logic                  w_clear;
  logic                  w_dec;
  logic                  w_zero_c;
  mmss_t                 w_load_val;
  mmss_t                 w_digits;

  assign w_abort    = conflicting_values | stop_button | ~irrigation_on;
  assign w_go       = irrigation_on & ~conflicting_values & ~stop_button;
  assign w_tick     = (r_state == RUN) && (r_prescale == TICK_LAST);
  assign w_load_val = sprinkler_mode_on ? SPRINKLER_PRESET : DRIPPER_PRESET;

  // Prescaler idles at 0 outside RUN, so every load starts a full second.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
    end else if ((r_state != RUN) || w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= w_running_next;
      r_done    <= w_done_next;
      r_aborted <= w_aborted_next;
    end
  end

  // Abort outranks a same-cycle tick.
  always_comb begin
    w_state_next   = r_state;
    w_running_next = 1'b0;
    w_done_next    = 1'b0;
    w_aborted_next = 1'b0;
    w_load         = 1'b0;
    w_clear        = 1'b0;
    w_dec          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          w_state_next   = RUN;
          w_load         = 1'b1;
          w_running_next = 1'b1;
        end
      end
      RUN: begin
        if (w_abort) begin
          w_state_next   = IDLE;
          w_clear        = 1'b1;
          w_aborted_next = 1'b1;
        end else begin
          w_running_next = 1'b1;
          if (w_tick) begin
            w_dec = 1'b1;
            if (w_digits == ONE_SECOND) begin
              w_state_next   = DONE;
              w_running_next = 1'b0;
              w_done_next    = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (!irrigation_on) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_clear      = 1'b1;
      end
    endcase
  end

  bcd_mmss_down_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_digits   (w_digits),
    .o_zero_c   (w_zero_c)
  );

  assign minutes_d = w_digits.min_d;
  assign minutes_u = w_digits.min_u;
  assign seconds_d = w_digits.sec_d;
  assign seconds_u = w_digits.sec_u;
  assign running   = r_running;
  assign done      = r_done;
  assign aborted   = r_aborted;

  a_pulses_exclusive: assert property (@(posedge clock) disable iff (reset) !(r_done && r_aborted));
  a_done_is_zero:     assert property (@(posedge clock) disable iff (reset) (r_state != DONE) || w_zero_c);

endmodule

// File: tb/tb_irrigation_countdown_timer.sv
// Scoreboard bench: a 4-cycle-tick 00:03 instance and a 1-cycle-tick 10:00 dripper instance.
module tb_irrigation_countdown_timer;

  typedef struct {
    string       tag;
    logic [17:0] val;
  } exp_t;

  logic clk;
  logic rst_a, irr_a, conf_a, mode_a, stop_a;
  logic rst_b, irr_b, conf_b, mode_b, stop_b;
  logic [3:0] md_a, mu_a, su_a, md_b, mu_b, su_b;
  logic [2:0] sd_a, sd_b;
  logic run_a, done_a, ab_a, run_b, done_b, ab_b;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  int   done_pulses_b;

  irrigation_countdown_timer #(
    .TICKS_PER_SECOND (4),
    .SPRINKLER_MIN    (0),
    .SPRINKLER_SEC    (3)
  ) dut_a (
    .clock (clk), .reset (rst_a), .irrigation_on (irr_a), .conflicting_values (conf_a),
    .sprinkler_mode_on (mode_a), .stop_button (stop_a),
    .minutes_d (md_a), .minutes_u (mu_a), .seconds_d (sd_a), .seconds_u (su_a),
    .running (run_a), .done (done_a), .aborted (ab_a)
  );

  irrigation_countdown_timer #(
    .TICKS_PER_SECOND (1),
    .DRIPPER_MIN      (10),
    .DRIPPER_SEC      (0)
  ) dut_b (
    .clock (clk), .reset (rst_b), .irrigation_on (irr_b), .conflicting_values (conf_b),
    .sprinkler_mode_on (mode_b), .stop_button (stop_b),
    .minutes_d (md_b), .minutes_u (mu_b), .seconds_d (sd_b), .seconds_u (su_b),
    .running (run_b), .done (done_b), .aborted (ab_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input bit r, input bit d, input bit a,
                                     input int md, input int mu, input int sd, input int su);
    return {r, d, a, 4'(md), 4'(mu), 3'(sd), 4'(su)};
  endfunction

  function automatic logic [17:0] obs_a();
    return {run_a, done_a, ab_a, md_a, mu_a, sd_a, su_a};
  endfunction

  function automatic logic [17:0] obs_b();
    return {run_b, done_b, ab_b, md_b, mu_b, sd_b, su_b};
  endfunction

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got run/done/ab=%b%b%b digits=%0d%0d:%0d%0d, want run/done/ab=%b%b%b digits=%0d%0d:%0d%0d",
               tag, got[17], got[16], got[15], got[14:11], got[10:7], got[6:4], got[3:0],
               want[17], want[16], want[15], want[14:11], want[10:7], want[6:4], want[3:0]);
    end
  endtask

  task automatic expect_v(input string tag, input logic [17:0] v);
    sb_q.push_back('{tag: tag, val: v});
  endtask

  task automatic pop_chk(input logic [17:0] got);
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_chk_a(input string tag, input logic [17:0] v);
    expect_v(tag, v);
    step();
    pop_chk(obs_a());
  endtask

  initial begin
    int ticks, rem, mm, ss;
    n_vec = 0; n_err = 0; done_pulses_b = 0;
    rst_a = 1'b1; irr_a = 1'b0; conf_a = 1'b0; mode_a = 1'b0; stop_a = 1'b0;
    rst_b = 1'b1; irr_b = 1'b0; conf_b = 1'b0; mode_b = 1'b0; stop_b = 1'b0;
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0;
    step_chk_a("reset_a", pk(0, 0, 0, 0, 0, 0, 0));
    expect_v("reset_b", pk(0, 0, 0, 0, 0, 0, 0));
    pop_chk(obs_b());

    // Basic countdown 00:03 with 4-cycle ticks.
    irr_a = 1'b1; mode_a = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      ticks = (k - 1) / 4;
      if (ticks > 3) ticks = 3;
      step_chk_a($sformatf("count_k%0d", k), pk(k < 13, k == 13, 0, 0, 0, 0, 3 - ticks));
    end
    for (int k = 0; k < 3; k++) step_chk_a("done_hold", pk(0, 0, 0, 0, 0, 0, 0));
    stop_a = 1'b1; conf_a = 1'b1;
    step_chk_a("done_ignores_abort", pk(0, 0, 0, 0, 0, 0, 0));
    stop_a = 1'b0; conf_a = 1'b0; irr_a = 1'b0;
    step_chk_a("done_to_idle", pk(0, 0, 0, 0, 0, 0, 0));

    // Abort coincident with the tick at 00:02.
    irr_a = 1'b1; mode_a = 1'b1;
    step_chk_a("abort_load", pk(1, 0, 0, 0, 0, 0, 3));
    repeat (3) step();
    step_chk_a("abort_at2", pk(1, 0, 0, 0, 0, 0, 2));
    repeat (2) step();
    step_chk_a("abort_pre_tick", pk(1, 0, 0, 0, 0, 0, 2));
    stop_a = 1'b1;
    step_chk_a("abort_pulse", pk(0, 0, 1, 0, 0, 0, 0));
    stop_a = 1'b0; irr_a = 1'b0;
    step_chk_a("abort_idle", pk(0, 0, 0, 0, 0, 0, 0));

    // Conflict blocks load in IDLE.
    irr_a = 1'b1; conf_a = 1'b1;
    for (int k = 0; k < 3; k++) step_chk_a("conf_no_load", pk(0, 0, 0, 0, 0, 0, 0));
    conf_a = 1'b0;
    step_chk_a("conf_release_load", pk(1, 0, 0, 0, 0, 0, 3));

    // Mode toggles during RUN do not disturb the countdown.
    mode_a = 1'b0;
    repeat (3) step();
    mode_a = 1'b1;
    step_chk_a("mode_toggle_2", pk(1, 0, 0, 0, 0, 0, 2));
    mode_a = 1'b0;
    repeat (3) step();
    step_chk_a("mode_toggle_1", pk(1, 0, 0, 0, 0, 0, 1));
    irr_a = 1'b0;
    step_chk_a("irr_drop_abort", pk(0, 0, 1, 0, 0, 0, 0));
    step_chk_a("irr_drop_idle", pk(0, 0, 0, 0, 0, 0, 0));
    irr_a = 1'b1; mode_a = 1'b0;
    step_chk_a("dripper_load", pk(1, 0, 0, 3, 0, 0, 0));
    repeat (2) step();

    // Asynchronous reset between edges.
    #2 rst_a = 1'b1;
    #1;
    expect_v("async_reset", pk(0, 0, 0, 0, 0, 0, 0));
    pop_chk(obs_a());
    step_chk_a("reset_held", pk(0, 0, 0, 0, 0, 0, 0));
    rst_a = 1'b0;
    step_chk_a("resume_after_reset", pk(1, 0, 0, 3, 0, 0, 0));
    irr_a = 1'b0;
    step_chk_a("final_abort_a", pk(0, 0, 1, 0, 0, 0, 0));

    // Borrow chain: dripper 10:00, tick every cycle.
    irr_b = 1'b1; mode_b = 1'b0;
    for (int k = 1; k <= 602; k++) begin
      rem = (k - 1 >= 600) ? 0 : 600 - (k - 1);
      mm = rem / 60; ss = rem % 60;
      expect_v($sformatf("borrow_k%0d", k), pk(k <= 600, k == 601, 0, mm / 10, mm % 10, ss / 10, ss % 10));
      step();
      if (done_b) done_pulses_b++;
      pop_chk(obs_b());
    end
    expect_v("done_pulse_count", 18'(1));
    pop_chk(18'(done_pulses_b));
    irr_b = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
